fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 16 +
 rtl/exec_timer.sv | 28 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch sequencing states, decode counter width, reset PC.
package cpu_pkg;

  localparam int unsigned CNT_W = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/exec_timer.sv
// Execute-cycle down-counter: loaded at issue, counts EXEC cycles, flags the final one.
module exec_timer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_remain;

  // Saturates at zero so a stray decrement can never wrap into a long stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remain <= '0;
    end else if (i_load) begin
      r_remain <= i_load_val;
    end else if (i_dec && (r_remain != '0)) begin
      r_remain <= r_remain - CNT_W'(1);
    end
  end

  assign o_last_c = (r_remain == CNT_W'(1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: owns the PC, reads the instruction BRAM,
// issues pc/inst to decode and paces the next fetch by decode's execute count.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned INST_SIZE = 10,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [INST_SIZE-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic [31:0]          npc,
  input  logic [CNT_W-1:0]     counter,
  input  logic                 stop,
  output logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic                 halted,
  output logic [31:0]          retired
);

  fetch_state_t r_state, w_state_n;

  logic [31:0]          r_pc, w_pc_n;
  logic [31:0]          r_pc_next, w_pc_next_n;
  logic [31:0]          r_inst, w_inst_n;
  logic [31:0]          r_retired, w_retired_n;
  logic [INST_SIZE-1:0] r_addr, w_addr_n;
  logic                 r_valid, w_valid_n;
  logic                 r_halted, w_halted_n;
  logic                 w_tmr_load, w_tmr_dec, w_tmr_last;

  exec_timer u_exec_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (counter),
    .i_dec      (w_tmr_dec),
    .o_last_c   (w_tmr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_pc_next <= RESET_PC;
      r_inst    <= '0;
      r_retired <= '0;
      r_addr    <= RESET_PC[INST_SIZE+1:2];
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_pc_next <= w_pc_next_n;
      r_inst    <= w_inst_n;
      r_retired <= w_retired_n;
      r_addr    <= w_addr_n;
      r_valid   <= w_valid_n;
      r_halted  <= w_halted_n;
    end
  end

  // The BRAM address is updated on entry to FETCH so the word is readable during LOAD.
  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_pc_next_n = r_pc_next;
    w_inst_n    = r_inst;
    w_retired_n = r_retired;
    w_addr_n    = r_addr;
    w_valid_n   = 1'b0;
    w_halted_n  = r_halted;
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_n  = r_pc[INST_SIZE+1:2];
          w_state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_n = S_LOAD;
      end
      S_LOAD: begin
        w_inst_n  = imem_rdata;
        w_valid_n = 1'b1;
        w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (stop) begin
          w_halted_n = 1'b1;
          w_state_n  = S_HALT;
        end else begin
          w_retired_n = r_retired + 32'd1;
          w_pc_next_n = npc;
          w_tmr_load  = 1'b1;
          if (counter == '0) begin
            w_pc_n    = npc;
            w_addr_n  = npc[INST_SIZE+1:2];
            w_state_n = S_FETCH;
          end else begin
            w_state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_last) begin
          w_pc_n    = r_pc_next;
          w_addr_n  = r_pc_next[INST_SIZE+1:2];
          w_state_n = S_FETCH;
        end
      end
      S_HALT: begin
        w_state_n = S_HALT;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign imem_addr  = r_addr;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_valid;
  assign halted     = r_halted;
  assign retired    = r_retired;

endmodule
